// File: rtl/winlb_pkg.sv
// ============================================================================
//  Module : winlb_pkg
//  Brief  : Shared window/pixel definitions for the line buffer and the
//           81-tap theta inner-product stage.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package winlb_pkg;

  localparam int C_PIX_W     = 7;
  localparam int C_WIN       = 9;
  localparam int C_WIN_ELEMS = C_WIN * C_WIN;

  typedef logic [C_PIX_W-1:0] pix_t;

endpackage

`default_nettype wire

// File: rtl/winlb_row_mem.sv
// ============================================================================
//  Module : winlb_row_mem
//  Brief  : One image row of pixels; combinational read, synchronous write.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module winlb_row_mem #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 7,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Contents are deliberately not reset; validity is tracked by the counters.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/window_linebuffer9.sv
// ============================================================================
//  Module : window_linebuffer9
//  Brief  : Raster line buffer producing a registered WIN x WIN window.
//           Optional start-of-frame input enabled by WINLB_FRAME_SYNC_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module window_linebuffer9
  import winlb_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int WIN   = C_WIN,
  parameter int PIX_W = C_PIX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
`ifdef WINLB_FRAME_SYNC_EN
  input  logic                     sof,
`endif
  output logic [WIN*WIN*PIX_W-1:0] win_flat,
  output logic                     win_valid,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_X_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_X_FIRST = CW'(WIN - 1);
  localparam logic [RW-1:0] C_Y_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] C_Y_FIRST = RW'(WIN - 1);

  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [WIN-1:0][WIN-1:0][PIX_W-1:0] win_q, win_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;

  logic [CW-1:0] w_x;
  logic [RW-1:0] w_y;
  logic [WIN-2:0][PIX_W-1:0] w_rd;
  logic [WIN-1:0][PIX_W-1:0] w_colv;

  // Effective pixel position; sof relocates the current pixel to (0,0).
  always_comb begin
    w_x = col_cnt_q;
    w_y = row_cnt_q;
`ifdef WINLB_FRAME_SYNC_EN
    if (sof) begin
      w_x = '0;
      w_y = '0;
    end
`endif
  end

  always_comb begin
    w_colv = '0;
    for (int r = 0; r < WIN - 1; r++) begin
      w_colv[r] = w_rd[r];
    end
    w_colv[WIN-1] = pix_in;
  end

  // Each row memory takes the column entry of the row below: a per-column shift.
  for (genvar r = 0; r < WIN - 1; r++) begin : g_rowmem
    winlb_row_mem #(
      .DEPTH (IMG_W),
      .WIDTH (PIX_W),
      .AW    (CW)
    ) u_row_mem (
      .clk     (clk),
      .we_i    (pix_valid),
      .addr_i  (w_x),
      .wdata_i (w_colv[r+1]),
      .rdata_o (w_rd[r])
    );
  end

  always_comb begin
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (pix_valid) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][WIN-1] = w_colv[r];
      end
      win_valid_d = (w_x >= C_X_FIRST) && (w_y >= C_Y_FIRST);
      if (w_x == C_X_LAST) begin
        col_cnt_d = '0;
        if (w_y == C_Y_LAST) begin
          row_cnt_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          row_cnt_d = w_y + 1'b1;
        end
      end else begin
        col_cnt_d = w_x + 1'b1;
        row_cnt_d = w_y;
      end
    end
`ifdef WINLB_FRAME_SYNC_EN
    else if (sof) begin
      col_cnt_d = '0;
      row_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_flat   = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_window_linebuffer9.sv
// ============================================================================
//  Module : tb_window_linebuffer9
//  Brief  : Self-checking bench for window_linebuffer9 (scoreboard of windows).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_window_linebuffer9;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int WIN   = 9;
  localparam int PIX_W = 7;
  localparam int FW    = WIN * WIN * PIX_W;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NWIN  = (IMG_W - WIN + 1) * (IMG_H - WIN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
`ifdef WINLB_FRAME_SYNC_EN
  logic             sof;
`endif
  logic [FW-1:0]    win_flat;
  logic             win_valid;
  logic             frame_done;

  int errors = 0;
  int checks = 0;

  logic [FW-1:0] sb_q [$];
  int            nwin;
  int            straddle_hits;
  logic [FW-1:0] first_win;
  logic [FW-1:0] win_89;

  window_linebuffer9 #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN   (WIN),
    .PIX_W (PIX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
`ifdef WINLB_FRAME_SYNC_EN
    .sof        (sof),
`endif
    .win_flat   (win_flat),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [PIX_W-1:0] pixv(input int x, input int y, input int off);
    return PIX_W'((y * IMG_W + x + off) % 128);
  endfunction

  // Reference window taken straight from the image positions.
  function automatic logic [FW-1:0] exp_win(input int x, input int y, input int off);
    logic [FW-1:0] w;
    w = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        w[(r*WIN+c)*PIX_W +: PIX_W] = pixv(x - WIN + 1 + c, y - WIN + 1 + r, off);
      end
    end
    return w;
  endfunction

  task automatic set_sof(input bit s);
`ifdef WINLB_FRAME_SYNC_EN
    sof = s;
`else
    if (s) $display("note: sof requested without frame sync build");
`endif
  endtask

  // Streams npix pixels of a frame pattern starting at (0,0), checking every cycle.
  task automatic stream(input int off, input int npix, input int gap_pct, input bit sof_first);
    logic [FW-1:0] e;
    bit            exp_v;
    nwin          = 0;
    straddle_hits = 0;
    for (int i = 0; i < npix; i++) begin
      int x;
      int y;
      x = i % IMG_W;
      y = i / IMG_W;
      if (gap_pct > 0) begin
        for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
          pix_valid = 1'b0;
          set_sof(1'b0);
          pix_in    = PIX_W'($urandom);
          @(posedge clk); #1;
          checks++;
          if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL gap_quiet: win_valid=%b frame_done=%b want 0 0", win_valid, frame_done);
          end
        end
      end
      pix_valid = 1'b1;
      pix_in    = pixv(x, y, off);
      set_sof(sof_first && i == 0);
      exp_v = (x >= WIN - 1) && (y >= WIN - 1);
      if (exp_v) sb_q.push_back(exp_win(x, y, off));
      @(posedge clk); #1;
      checks++;
      if (win_valid !== exp_v) begin
        errors++;
        $display("FAIL valid_flag (%0d,%0d): got %b want %b", x, y, win_valid, exp_v);
      end
      if (win_valid === 1'b1) begin
        nwin++;
        if (x < WIN - 1) straddle_hits++;
        if (nwin == 1) first_win = win_flat;
        if (x == 8 && y == 9) win_89 = win_flat;
      end
      if (exp_v) begin
        e = sb_q.pop_front();
        checks++;
        if (win_flat !== e) begin
          errors++;
          $display("FAIL window (%0d,%0d): got %h want %h", x, y, win_flat, e);
        end
      end
      checks++;
      if (frame_done !== (i == NPIX - 1)) begin
        errors++;
        $display("FAIL frame_done at pixel %0d: got %b want %b", i, frame_done, (i == NPIX - 1));
      end
    end
    pix_valid = 1'b0;
    set_sof(1'b0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_in    = '0;
    set_sof(1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_flat !== '0) begin
      errors++;
      $display("FAIL reset_state: win_valid=%b frame_done=%b win_flat_nonzero=%b want 0 0 0",
               win_valid, frame_done, (win_flat != '0));
    end
    rst = 1'b0;
  endtask

  task automatic test_gapless();
    stream(0, NPIX, 0, 1'b0);
    checks++;
    if (nwin != NWIN) begin
      errors++;
      $display("FAIL gapless_count: got %0d want %0d", nwin, NWIN);
    end
    checks++;
    if (first_win[0 +: PIX_W] !== 7'd0 || first_win[80*PIX_W +: PIX_W] !== 7'd104) begin
      errors++;
      $display("FAIL first_window: elem0=%0d elem80=%0d want 0 104",
               first_win[0 +: PIX_W], first_win[80*PIX_W +: PIX_W]);
    end
  endtask

  task automatic test_gaps();
    stream(0, NPIX, 30, 1'b0);
    checks++;
    if (nwin != NWIN) begin
      errors++;
      $display("FAIL gaps_count: got %0d want %0d", nwin, NWIN);
    end
  endtask

  task automatic test_straddle();
    stream(0, NPIX, 0, 1'b0);
    checks++;
    if (straddle_hits != 0) begin
      errors++;
      $display("FAIL straddle: got %0d valid strobes at x<8 want 0", straddle_hits);
    end
    checks++;
    if (win_89[0 +: PIX_W] !== 7'd28 || win_89[80*PIX_W +: PIX_W] !== 7'd4) begin
      errors++;
      $display("FAIL window_8_9: elem0=%0d elem80=%0d want 28 4",
               win_89[0 +: PIX_W], win_89[80*PIX_W +: PIX_W]);
    end
  endtask

  task automatic test_back_to_back();
    stream(77, NPIX, 0, 1'b0);
    checks++;
    if (nwin != NWIN) begin
      errors++;
      $display("FAIL b2b_first_count: got %0d want %0d", nwin, NWIN);
    end
    stream(0, NPIX, 0, 1'b0);
    checks++;
    if (nwin != NWIN) begin
      errors++;
      $display("FAIL b2b_second_count: got %0d want %0d", nwin, NWIN);
    end
  endtask

  task automatic test_mid_reset();
    stream(50, 300, 0, 1'b0);
    rst       = 1'b1;
    pix_valid = 1'b1;
    pix_in    = 7'h55;
    @(posedge clk); #1;
    checks++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_flat !== '0) begin
      errors++;
      $display("FAIL mid_reset: win_valid=%b frame_done=%b win_flat_nonzero=%b want 0 0 0",
               win_valid, frame_done, (win_flat != '0));
    end
    rst       = 1'b0;
    pix_valid = 1'b0;
    stream(0, NPIX, 0, 1'b0);
    checks++;
    if (nwin != NWIN) begin
      errors++;
      $display("FAIL mid_reset_count: got %0d want %0d", nwin, NWIN);
    end
  endtask

`ifdef WINLB_FRAME_SYNC_EN
  task automatic test_sof();
    stream(0, 100, 0, 1'b0);
    stream(33, NPIX, 0, 1'b1);
    checks++;
    if (nwin != NWIN) begin
      errors++;
      $display("FAIL sof_pixel_count: got %0d want %0d", nwin, NWIN);
    end
    stream(0, 50, 0, 1'b0);
    set_sof(1'b1);
    pix_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL sof_idle: win_valid=%b frame_done=%b want 0 0", win_valid, frame_done);
    end
    set_sof(1'b0);
    stream(0, NPIX, 0, 1'b0);
    checks++;
    if (nwin != NWIN) begin
      errors++;
      $display("FAIL sof_idle_count: got %0d want %0d", nwin, NWIN);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_gapless();
    test_gaps();
    test_straddle();
    test_back_to_back();
    test_mid_reset();
`ifdef WINLB_FRAME_SYNC_EN
    test_sof();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
